// File: rtl/spram_mem_ctrl_pkg.sv
// Shared definitions for the SPRAM data-memory controller: access size
// encodings, controller state enum and the store byte-lane helpers.
package spram_mem_ctrl_pkg;

    // Access size encodings carried on req_size (3 behaves as word).
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_STANDBY = 3'd3,
        ST_SLEEP   = 3'd4,
        ST_WAKE    = 3'd5
    } state_t;

    // Nibble write mask for MASKWREN; two mask bits cover one byte lane.
    function automatic logic [7:0] mem_mask_gen(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 8'b0000_0011 << {addr_lo, 1'b0};
            SZ_HALF: return addr_lo[1] ? 8'hF0 : 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

    // Replicate right-aligned store data onto every lane so the mask alone
    // decides which lanes the SPRAM actually writes.
    function automatic logic [31:0] store_data(input logic [1:0]  size,
                                               input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/spram_load_align.sv
// Combinational load-data lane select plus sign/zero extension. Little-endian
// lanes: lane b is data[8b+7:8b]. Usable by any load path reading a 32-bit word.
module spram_load_align
    import spram_mem_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_fill;
    logic        half_fill;

    // Pick the addressed lane(s), then extend to 32 bits.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_fill = ~is_unsigned & byte_sel[7];
        half_fill = ~is_unsigned & half_sel[15];
        case (size)
            SZ_BYTE: data = {{24{byte_fill}}, byte_sel};
            SZ_HALF: data = {{16{half_fill}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/spram_mem_ctrl.sv
// Initiator-side controller for the cascaded 16K x 32 SPRAM data memory.
// Serves byte/half/word loads and stores, one at a time, and manages SPRAM
// power: STANDBY then SLEEP after idle periods, with a timed wake-up.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE and never during reset. Once accepted, exactly
// one rsp_valid pulse follows (unless reset intervenes); the next request may be
// accepted on the same cycle rsp_valid is high.
module spram_mem_ctrl
    import spram_mem_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_STBY  = 64,
    parameter int unsigned IDLE_SLEEP = 1024,
    parameter int unsigned WAKE_STBY  = 1,
    parameter int unsigned WAKE_SLEEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_mask,
    output logic        mem_wren,
    output logic        mem_cs,
    output logic        mem_standby,
    output logic        mem_sleep,
    output logic        mem_poweroff,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] STBY_N  = 16'(IDLE_STBY);
    localparam logic [15:0] SLEEP_N = 16'(IDLE_SLEEP);
    localparam logic [15:0] WAKE_S  = 16'(WAKE_STBY);
    localparam logic [15:0] WAKE_L  = 16'(WAKE_SLEEP);

    state_t      state;
    logic [15:0] idle_cnt;
    logic [15:0] idle_cnt_inc;
    logic [15:0] wake_cnt;

    // Request attributes held for the response phase.
    logic        lat_we;
    logic [1:0]  lat_addr_lo;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] load_data;

    // The SPRAM is never powered off by this controller.
    assign mem_poweroff = 1'b1;

    // Ready only in IDLE so at most one request is ever in flight.
    assign req_ready = (state == ST_IDLE) && !reset;

    // Saturating idle counter increment.
    assign idle_cnt_inc = (idle_cnt == 16'hFFFF) ? idle_cnt : idle_cnt + 16'd1;

    spram_load_align u_align (
        .rdata       (mem_rdata),
        .addr_lo     (lat_addr_lo),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .data        (load_data)
    );

    // Controller FSM: access sequencing, responses and power management.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            idle_cnt     <= '0;
            wake_cnt     <= '0;
            lat_we       <= 1'b0;
            lat_addr_lo  <= 2'b00;
            lat_size     <= SZ_BYTE;
            lat_unsigned <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_mask     <= '0;
            mem_wren     <= 1'b0;
            mem_cs       <= 1'b0;
            mem_standby  <= 1'b0;
            mem_sleep    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Accept has priority over a coincident standby entry.
                        idle_cnt     <= '0;
                        lat_we       <= req_we;
                        lat_addr_lo  <= req_addr[1:0];
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            // No SPRAM cycle; report the error right away.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            mem_addr  <= req_addr[15:2];
                            mem_wdata <= store_data(req_size, req_wdata);
                            mem_mask  <= mem_mask_gen(req_size, req_addr[1:0]);
                            mem_wren  <= req_we;
                            mem_cs    <= 1'b1;
                            state     <= ST_ACCESS;
                        end
                    end else if (STBY_N != 16'd0 && idle_cnt_inc == STBY_N) begin
                        state       <= ST_STANDBY;
                        mem_standby <= 1'b1;
                        idle_cnt    <= '0;
                    end else begin
                        idle_cnt <= idle_cnt_inc;
                    end
                end
                ST_ACCESS: begin
                    // The SPRAM edge has happened; release the chip select.
                    mem_cs   <= 1'b0;
                    mem_wren <= 1'b0;
                    if (lat_we) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // DATAOUT is valid this cycle.
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_data;
                    state     <= ST_IDLE;
                end
                ST_STANDBY: begin
                    if (req_valid) begin
                        mem_standby <= 1'b0;
                        wake_cnt    <= WAKE_S;
                        idle_cnt    <= '0;
                        state       <= ST_WAKE;
                    end else if (SLEEP_N != 16'd0 && idle_cnt_inc == SLEEP_N) begin
                        mem_standby <= 1'b0;
                        mem_sleep   <= 1'b1;
                        idle_cnt    <= '0;
                        state       <= ST_SLEEP;
                    end else begin
                        idle_cnt <= idle_cnt_inc;
                    end
                end
                ST_SLEEP: begin
                    if (req_valid) begin
                        mem_sleep <= 1'b0;
                        wake_cnt  <= WAKE_L;
                        idle_cnt  <= '0;
                        state     <= ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    // Hold off accesses until the SPRAM has recovered.
                    if (wake_cnt <= 16'd1) begin
                        state <= ST_IDLE;
                    end
                    if (wake_cnt != 16'd0) begin
                        wake_cnt <= wake_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_mem_ctrl.sv
// Self-checking bench for spram_mem_ctrl: a table of directed vectors, power
// management sequences, reset during an access, and randomized traffic checked
// against a byte-addressed reference memory.
module tb_spram_mem_ctrl;

    localparam int IDLE_STBY  = 4;
    localparam int IDLE_SLEEP = 8;
    localparam int WAKE_STBY  = 1;
    localparam int WAKE_SLEEP = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_wren;
    logic        mem_cs;
    logic        mem_standby;
    logic        mem_sleep;
    logic        mem_poweroff;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q[$];
    logic [7:0]  ref_mem [0:255];

    spram_mem_ctrl #(
        .IDLE_STBY  (IDLE_STBY),
        .IDLE_SLEEP (IDLE_SLEEP),
        .WAKE_STBY  (WAKE_STBY),
        .WAKE_SLEEP (WAKE_SLEEP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_mask     (mem_mask),
        .mem_wren     (mem_wren),
        .mem_cs       (mem_cs),
        .mem_standby  (mem_standby),
        .mem_sleep    (mem_sleep),
        .mem_poweroff (mem_poweroff),
        .mem_rdata    (mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- SPRAM model (registered read, nibble-masked write) ----------------
    logic [31:0] spram [0:16383];
    logic [31:0] spram_q;
    logic [31:0] bit_mask;

    assign bit_mask = {{4{mem_mask[7]}}, {4{mem_mask[6]}}, {4{mem_mask[5]}}, {4{mem_mask[4]}},
                       {4{mem_mask[3]}}, {4{mem_mask[2]}}, {4{mem_mask[1]}}, {4{mem_mask[0]}}};
    assign mem_rdata = spram_q;

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wren)
                spram[mem_addr] <= (spram[mem_addr] & ~bit_mask) | (mem_wdata & bit_mask);
            else
                spram_q <= spram[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    function automatic int ref_nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic ref_misaligned(input logic [1:0] size, input logic [15:0] addr);
        return (int'(addr) % ref_nbytes(size)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [15:0] addr, input logic [1:0] size,
                                             input logic uns);
        int nb = ref_nbytes(size);
        logic [31:0] v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) & 255];
        if (!uns) for (int j = 8*nb; j < 32; j++) v[j] = v[8*nb-1];
        return v;
    endfunction

    task automatic ref_store(input logic [15:0] addr, input logic [1:0] size, input logic [31:0] d);
        for (int i = 0; i < ref_nbytes(size); i++) ref_mem[(int'(addr) + i) & 255] = d[8*i +: 8];
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er, output int lat, output int waits,
                          output logic cs1, output logic cs_any, output logic [13:0] a1,
                          output logic [7:0] m1, output logic [31:0] w1, output logic wren1);
        logic [32:0] exp;
        logic [32:0] got;
        int exp_lat;
        rd = '0; er = 1'b0; lat = 0; waits = 0; cs1 = 1'b0; cs_any = 1'b0;
        a1 = '0; m1 = '0; w1 = '0; wren1 = 1'b0;
        if (ref_misaligned(size, addr)) begin
            exp = {1'b1, 32'h0}; exp_lat = 1;
        end else if (we) begin
            ref_store(addr, size, wdata); exp = {1'b0, 32'h0}; exp_lat = 2;
        end else begin
            exp = {1'b0, ref_load(addr, size, uns)}; exp_lat = 3;
        end
        exp_q.push_back(exp);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        while (!req_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: req_ready low for %0d cycles, required high", waits);
            req_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        cs1 = mem_cs; cs_any = mem_cs; a1 = mem_addr; m1 = mem_mask; w1 = mem_wdata; wren1 = mem_wren;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            cs_any = cs_any | mem_cs;
        end
        got = exp_q.pop_front();
        if (!rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, required at %0d", lat, exp_lat);
            return;
        end
        rd = rsp_rdata; er = rsp_err;
        check("sb_rdata", rd, got[31:0]);
        check("sb_err", 32'(er), 32'(got[32]));
        check("sb_latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        cs_any = cs_any | mem_cs;
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [7:0]  exp_mask;
        logic [31:0] exp_wdata;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd, w1;
        logic        er, cs1, cs_any, wren1, saw;
        logic [13:0] a1;
        logic [7:0]  m1;
        int          lat, waits, first_stby, first_sleep;

        //          we    addr    sz uns wdata          rdata          err lat mask   wdata
        vecs[0]  = '{1'b1, 16'h0010, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 8'hFF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 16'h0010, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 3, 8'hFF, 32'h0};
        vecs[2]  = '{1'b1, 16'h0013, 2'd0, 1'b0, 32'h00000080, 32'h00000000, 1'b0, 2, 8'hC0, 32'h80808080};
        vecs[3]  = '{1'b0, 16'h0013, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 3, 8'hC0, 32'h0};
        vecs[4]  = '{1'b0, 16'h0013, 2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0, 3, 8'hC0, 32'h0};
        vecs[5]  = '{1'b0, 16'h0010, 2'd2, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0, 3, 8'hFF, 32'h0};
        vecs[6]  = '{1'b1, 16'h0012, 2'd1, 1'b0, 32'h00001234, 32'h00000000, 1'b0, 2, 8'hF0, 32'h12341234};
        vecs[7]  = '{1'b0, 16'h0010, 2'd1, 1'b1, 32'h0,        32'h0000BEEF, 1'b0, 3, 8'h0F, 32'h0};
        vecs[8]  = '{1'b0, 16'h0002, 2'd2, 1'b0, 32'h0,        32'h00000000, 1'b1, 1, 8'h00, 32'h0};
        vecs[9]  = '{1'b0, 16'h0011, 2'd1, 1'b0, 32'h0,        32'h00000000, 1'b1, 1, 8'h00, 32'h0};
        vecs[10] = '{1'b1, 16'h0013, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 8'h00, 32'h0};
        vecs[11] = '{1'b0, 16'h0010, 2'd3, 1'b0, 32'h0,        32'h1234BEEF, 1'b0, 3, 8'hFF, 32'h0};
        vecs[12] = '{1'b0, 16'h0011, 2'd0, 1'b0, 32'h0,        32'hFFFFFFBE, 1'b0, 3, 8'h0C, 32'h0};
        vecs[13] = '{1'b0, 16'h0012, 2'd1, 1'b0, 32'h0,        32'h00001234, 1'b0, 3, 8'hF0, 32'h0};
        vecs[14] = '{1'b0, 16'h0010, 2'd1, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 8'h0F, 32'h0};
        vecs[15] = '{1'b1, 16'h0010, 2'd0, 1'b0, 32'hFFFFFFAB, 32'h00000000, 1'b0, 2, 8'h03, 32'hABABABAB};
        vecs[16] = '{1'b0, 16'h0010, 2'd2, 1'b1, 32'h0,        32'h1234BEAB, 1'b0, 3, 8'hFF, 32'h0};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_outs", {mem_wdata[15:0], mem_mask, 1'b0, mem_cs, mem_wren, mem_standby,
                               mem_sleep, mem_poweroff, 2'b00}, 32'h0000_0004);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                   rd, er, lat, waits, cs1, cs_any, a1, m1, w1, wren1);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (!vecs[i].exp_err) begin
                check($sformatf("v%0d_mem_addr", i), 32'(a1), 32'(vecs[i].addr[15:2]));
                check($sformatf("v%0d_mask", i), 32'(m1), 32'(vecs[i].exp_mask));
                check($sformatf("v%0d_cs", i), 32'(cs1), 32'd1);
                check($sformatf("v%0d_wren", i), 32'(wren1), 32'(vecs[i].we));
                if (vecs[i].we) check($sformatf("v%0d_wdata", i), w1, vecs[i].exp_wdata);
            end else begin
                check($sformatf("v%0d_no_cs", i), 32'(cs_any), 32'd0);
            end
        end

        // Idle -> STANDBY -> SLEEP timing, then wake from sleep.
        apply_reset(2);
        first_stby = -1; first_sleep = -1; saw = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_standby && first_stby < 0) first_stby = i;
            if (mem_sleep && first_sleep < 0) first_sleep = i;
            if (mem_cs || (mem_standby && mem_sleep)) saw = 1'b1;
        end
        check("stby_entry_cycle", 32'(first_stby), 32'(IDLE_STBY));
        check("sleep_entry_cycle", 32'(first_sleep), 32'(IDLE_STBY + IDLE_SLEEP));
        check("pwr_exclusive_no_cs", 32'(saw), 32'd0);
        check("sleep_pins", {30'd0, mem_sleep, mem_standby}, 32'd2);
        check("sleep_ready", 32'(req_ready), 32'd0);
        do_req(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0, rd, er, lat, waits, cs1, cs_any, a1, m1, w1, wren1);
        check("wake_sleep_waits", 32'(waits), 32'(1 + WAKE_SLEEP));
        check("wake_sleep_data", rd, 32'h1234BEAB);

        // Wake from STANDBY.
        apply_reset(2);
        repeat (6) @(negedge clk);
        check("stby_pin", 32'(mem_standby), 32'd1);
        do_req(1'b0, 16'h0012, 2'd1, 1'b1, 32'h0, rd, er, lat, waits, cs1, cs_any, a1, m1, w1, wren1);
        check("wake_stby_waits", 32'(waits), 32'(1 + WAKE_STBY));

        // Request on the cycle the idle counter would trigger standby: accept wins.
        apply_reset(2);
        repeat (2) @(negedge clk);
        do_req(1'b0, 16'h0013, 2'd0, 1'b1, 32'h0, rd, er, lat, waits, cs1, cs_any, a1, m1, w1, wren1);
        check("accept_wins_waits", 32'(waits), 32'd0);
        check("accept_wins_data", rd, 32'h00000012);

        // Reset during ACCESS of a load drops the response.
        @(negedge clk);
        req_we = 1'b0; req_addr = 16'h0010; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
        check("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_cs_in_access", 32'(mem_cs), 32'd1);
        reset = 1'b1;
        saw = 1'b0;
        repeat (3) begin @(posedge clk); #1; saw = saw | rsp_valid; end
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_mem_pins", {mem_mask, 5'd0, mem_cs, mem_wren, mem_standby, mem_sleep,
                                 mem_poweroff, 10'd0}, 32'h0000_0400);
        check("abort_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin @(posedge clk); #1; saw = saw | rsp_valid; end
        check("abort_no_rsp", 32'(saw), 32'd0);
        do_req(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0, rd, er, lat, waits, cs1, cs_any, a1, m1, w1, wren1);
        check("after_abort_data", rd, 32'h1234BEAB);

        // Randomized traffic against the reference memory.
        for (int w = 0; w < 16; w++)
            do_req(1'b1, 16'(16'h0040 + 4*w), 2'd2, 1'b0, $urandom,
                   rd, er, lat, waits, cs1, cs_any, a1, m1, w1, wren1);
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 14)) @(negedge clk);
            do_req(1'($urandom_range(0, 1)), 16'(16'h0040 + $urandom_range(0, 63)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                   rd, er, lat, waits, cs1, cs_any, a1, m1, w1, wren1);
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
